patternbuf_ctrl: RTL and testbench

Sequencer and access arbiter for the 32×8 serial pattern buffer. Loads the buffer by streaming host bytes MSB-first through the buffer's `ssel`/`sin` serial port, and serves random-access field reads by driving `fieldp` and capturing `field_byte`. Loads have priority over reads. Sits between the host/config interface and the pattern buffer in the pattern-processor datapath, on the same `sclk`.

---
 rtl/patternbuf_ctrl.sv | 147 ++++++++++++++
 tb/tb_patternbuf_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/patternbuf_ctrl.sv
// patternbuf_ctrl: streams host bytes MSB-first into the 32x8 serial pattern buffer and serves field reads.
// Optional feature macro PATBUF_READBACK_EN: capture the previous buffer contents from sout during a load.
module patternbuf_ctrl #(
    parameter int unsigned BUF_BYTES = 32,
    parameter int unsigned BYTE_W    = 8
) (
    input  logic                         sclk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic [BYTE_W-1:0]            wr_data,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    output logic                         ssel,
    output logic                         sin,
    input  logic                         sout,
    output logic [$clog2(BUF_BYTES)-1:0] fieldp,
    input  logic [BYTE_W-1:0]            field_byte,
    input  logic                         rd_req,
    input  logic [$clog2(BUF_BYTES)-1:0] rd_addr,
    output logic                         rd_ready,
    output logic [BYTE_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic                         busy,
    output logic                         load_done,
    output logic [BYTE_W-1:0]            rb_data,
    output logic                         rb_valid
);
    localparam int unsigned AW = $clog2(BUF_BYTES);
    localparam int unsigned BW = $clog2(BYTE_W);
    localparam logic [AW-1:0] LAST_BYTE = AW'(BUF_BYTES - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BYTE_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        READ
    } state_t;

    state_t            state;
    logic [BYTE_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [AW-1:0]     byte_cnt;
    logic              shift_end;

    assign wr_ready  = (state == WAIT_BYTE);
    assign rd_ready  = (state == IDLE) & ~load_start;
    assign shift_end = (state == SHIFT) && (bit_cnt == '0);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            ssel      <= 1'b0;
            sin       <= 1'b0;
            fieldp    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            rd_valid  <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= WAIT_BYTE;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                    end else if (rd_req) begin
                        state  <= READ;
                        fieldp <= rd_addr;
                        busy   <= 1'b1;
                    end
                end
                WAIT_BYTE: begin
                    // MSB goes straight onto sin so the buffer takes it on the very next edge
                    if (wr_valid) begin
                        sin     <= wr_data[BYTE_W-1];
                        shreg   <= {wr_data[BYTE_W-2:0], 1'b0};
                        ssel    <= 1'b1;
                        bit_cnt <= LAST_BIT;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_end) begin
                        ssel     <= 1'b0;
                        sin      <= 1'b0;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            load_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= WAIT_BYTE;
                        end
                    end else begin
                        sin     <= shreg[BYTE_W-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                READ: begin
                    rd_data  <= field_byte;
                    rd_valid <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PATBUF_READBACK_EN
    // Each byte streamed in pushes exactly one old byte out of sout, MSB first
    logic [BYTE_W-2:0] rb_shift;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rb_shift <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == SHIFT) begin
                rb_shift <= {rb_shift[BYTE_W-3:0], sout};
                if (shift_end) begin
                    rb_data  <= {rb_shift, sout};
                    rb_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_sout;
    assign unused_sout = sout;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_patternbuf_ctrl.sv
// Bench for patternbuf_ctrl: behavioural 256-bit serial buffer plus a transaction/timing reference model.
`timescale 1ns/1ps
module tb_patternbuf_ctrl;
    logic       sclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load_start = 1'b0, wr_valid = 1'b0, rd_req = 1'b0;
    logic [7:0] wr_data = '0;
    logic [4:0] rd_addr = '0;
    logic       wr_ready, ssel, sin, sout, rd_ready, rd_valid, busy, load_done, rb_valid;
    logic [4:0] fieldp;
    logic [7:0] field_byte, rd_data, rb_data;

    patternbuf_ctrl #(.BUF_BYTES(32), .BYTE_W(8)) dut (
        .sclk(sclk), .rst_n(rst_n), .load_start(load_start),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .ssel(ssel), .sin(sin), .sout(sout),
        .fieldp(fieldp), .field_byte(field_byte),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .load_done(load_done),
        .rb_data(rb_data), .rb_valid(rb_valid)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: actual=timeout required=event at %0t", name, $time);
    endtask

    // Pattern buffer: one 256-bit chain, sin enters bit 0 of byte 0, sout is bit 7 of byte 31
    logic [255:0] chain;
    logic [255:0] init_pattern;
    logic         preloaded = 1'b0;
    always @(posedge sclk) begin
        if (!preloaded) begin
            chain     <= init_pattern;
            preloaded <= 1'b1;
        end else if (ssel) begin
            chain <= {chain[254:0], sin};
        end
    end
    assign sout       = chain[255];
    assign field_byte = chain[{fieldp, 3'b000} +: 8];

    // Reference model: expected buffer image and spec timing (accept at E, shifts E+1..E+8)
    int         cyc = 0;
    bit         m_loading = 0, m_have_e = 0, m_rd_acc = 0;
    int         m_acc = 0, m_next_ok = 0, m_last_e = 0, m_rd_cyc = 0;
    logic [7:0] m_cur;
    logic [7:0] m_load [32];
    logic [7:0] m_mem  [32];
    logic [7:0] m_snap [32];
    bit         m_mem_known = 1, m_snap_known = 0, m_rd_known = 0;
    logic [7:0] m_rd_val;
    logic       e_ssel = 0, e_sin = 0, e_wr_ready = 0, e_busy = 0;
    logic       e_load_done = 0, e_rd_valid = 0, e_rb_valid = 0;
    logic [4:0] e_fieldp = '0;
    logic [7:0] e_rd_data = '0, e_rb_data = '0;
    bit         e_rd_known = 1, e_rb_known = 1;

    task automatic model_reset();
        if (m_loading) m_mem_known = 0;
        m_loading = 0; m_have_e = 0; m_rd_acc = 0;
        e_ssel = 0; e_sin = 0; e_wr_ready = 0; e_busy = 0;
        e_load_done = 0; e_rd_valid = 0; e_rb_valid = 0;
        e_fieldp = '0; e_rd_data = '0; e_rd_known = 1; e_rb_data = '0; e_rb_known = 1;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge sclk) begin
        bit idle_before;
        cyc++;
        if (rst_n) begin
            idle_before = !m_loading && !(m_rd_acc && m_rd_cyc == cyc - 1);
            e_load_done = 0; e_rd_valid = 0; e_rb_valid = 0;
            if (idle_before) begin
                if (load_start) begin
                    m_loading = 1; m_acc = 0; m_next_ok = cyc + 1; m_have_e = 0;
                    m_snap = m_mem; m_snap_known = m_mem_known;
                end else if (rd_req) begin
                    m_rd_acc = 1; m_rd_cyc = cyc; e_fieldp = rd_addr;
                    m_rd_val = m_mem[rd_addr]; m_rd_known = m_mem_known;
                end
            end else if (m_loading) begin
                if (m_have_e && cyc == m_last_e + 8) begin
`ifdef PATBUF_READBACK_EN
                    e_rb_valid = 1; e_rb_data = m_snap[31 - (m_acc - 1)]; e_rb_known = m_snap_known;
`endif
                    if (m_acc == 32) begin
                        m_loading = 0; e_load_done = 1;
                        for (int k = 0; k < 32; k++) m_mem[31 - k] = m_load[k];
                        m_mem_known = 1;
                    end
                end else if (m_acc < 32 && cyc >= m_next_ok && wr_valid) begin
                    m_load[m_acc] = wr_data; m_acc++;
                    m_last_e = cyc; m_have_e = 1; m_next_ok = cyc + 9; m_cur = wr_data;
                end
            end
            if (m_rd_acc && cyc == m_rd_cyc + 1) begin
                e_rd_valid = 1; e_rd_data = m_rd_val; e_rd_known = m_rd_known;
            end
            e_busy     = m_loading || (m_rd_acc && m_rd_cyc == cyc);
            e_ssel     = m_loading && m_have_e && (cyc - m_last_e) <= 7;
            e_sin      = e_ssel ? m_cur[7 - (cyc - m_last_e)] : 1'b0;
            e_wr_ready = m_loading && m_acc < 32 && (cyc + 1) >= m_next_ok;
        end
    end

    // Compare process, mid-cycle
    always @(negedge sclk) begin
        chk("ssel", ssel, e_ssel);
        if (e_ssel) chk("sin", sin, e_sin);
        chk("wr_ready", wr_ready, e_wr_ready);
        chk("rd_ready", rd_ready, !e_busy && !load_start);
        chk("busy", busy, e_busy);
        chk("load_done", load_done, e_load_done);
        chk("rd_valid", rd_valid, e_rd_valid);
        chk("fieldp", fieldp, e_fieldp);
        if (e_rd_known) chk("rd_data", rd_data, e_rd_data);
        chk("rb_valid", rb_valid, e_rb_valid);
        if (e_rb_known) chk("rb_data", rb_data, e_rb_data);
    end

`ifdef PATBUF_READBACK_EN
    int rb_a5 = 0;
    bit rb_count_en = 0;
    always @(negedge sclk) if (rb_count_en && rb_valid && rb_data == 8'hA5) rb_a5++;
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    logic [7:0] ld_bytes [32];
    int         load_span;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin tick(); n++; end
        if (busy !== 1'b0) fail_timeout("wait_idle");
    endtask

    task automatic do_read(input logic [4:0] addr, output logic [7:0] data);
        wait_idle();
        rd_addr = addr; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        data = rd_data;
    endtask

    task automatic do_load(input bit noise, input int pause_at, input int abort_at);
        int n, first_e;
        bit acc;
        wait_idle();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("start_wr_ready", wr_ready, 1'b1);
        chk("start_no_rd_valid", rd_valid, 1'b0);
        for (int k = 0; k < 32; k++) begin
            if (k == abort_at) begin
                repeat (3) tick();
                rst_n = 1'b0;
                #1;
                chk("abort_ctl", {ssel, sin, wr_ready, busy, load_done, rd_valid, rb_valid}, 0);
                chk("abort_fieldp", fieldp, 0);
                chk("abort_rd_data", rd_data, 0);
                chk("abort_rb_data", rb_data, 0);
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            if (k == pause_at) begin
                wr_valid = 1'b0;
                repeat (20) tick();
            end
            wr_data = ld_bytes[k];
            n = 0;
            forever begin
                wr_valid = (noise && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                if (noise) begin
                    rd_req = $urandom_range(0, 1); rd_addr = 5'($urandom);
                    load_start = $urandom_range(0, 1);
                end
                acc = wr_valid && wr_ready;
                tick();
                if (acc) break;
                n++;
                if (n > 100) begin fail_timeout("byte_accept"); break; end
            end
            if (k == 0) first_e = cyc;
            wr_valid = 1'b0; wr_data = 8'($urandom);
        end
        rd_req = noise ? 1'b0 : rd_req;
        load_start = 1'b0;
        n = 0;
        while (load_done !== 1'b1) begin
            if (n > 40) begin fail_timeout("load_done"); break; end
            tick(); n++;
        end
        load_span = cyc - first_e;
    endtask

    initial begin
        logic [7:0] d;
        for (int i = 0; i < 8; i++) init_pattern[i*32 +: 32] = $urandom;
        for (int j = 0; j < 32; j++) m_mem[j] = init_pattern[j*8 +: 8];
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_fieldp", fieldp, 0);
        chk("reset_ssel", ssel, 0);
        rst_n = 1'b1;
        tick();

        // Sequential load 0x00..0x1F, back-to-back
        for (int k = 0; k < 32; k++) ld_bytes[k] = 8'(k);
        do_load(0, -1, -1);
        chk("load_span", load_span, 287);
        do_read(5'd31, d); chk("read31", d, 8'h00);
        do_read(5'd0,  d); chk("read0",  d, 8'h1F);
        do_read(5'd16, d); chk("read16", d, 8'h0F);

        // Single read latency
        rd_addr = 5'd5; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("r5_fieldp", fieldp, 5);
        chk("r5_busy", busy, 1);
        chk("r5_early_valid", rd_valid, 0);
        tick();
        chk("r5_valid", rd_valid, 1);
        chk("r5_data", rd_data, 8'h1A);
        chk("r5_busy_end", busy, 0);

        // load_start and rd_req together, rd_req held through the load
        for (int k = 0; k < 32; k++) ld_bytes[k] = 8'(8'h40 + k);
        rd_addr = 5'd5; rd_req = 1'b1;
        do_load(0, -1, -1);
        tick();
        rd_req = 1'b0;
        chk("held_fieldp", fieldp, 5);
        tick();
        chk("held_valid", rd_valid, 1);
        chk("held_data", rd_data, 8'h5A);

        // Host stalls 20 cycles mid-load
        for (int k = 0; k < 32; k++) ld_bytes[k] = 8'($urandom);
        do_load(0, 16, -1);
        for (int i = 0; i < 4; i++) do_read(5'($urandom), d);

`ifdef PATBUF_READBACK_EN
        for (int k = 0; k < 32; k++) ld_bytes[k] = 8'hA5;
        do_load(0, -1, -1);
        for (int k = 0; k < 32; k++) ld_bytes[k] = 8'h3C;
        rb_count_en = 1;
        do_load(0, -1, -1);
        tick();
        rb_count_en = 0;
        chk("rb_a5_pulses", rb_a5, 32);
`endif

        // Reset during byte 10, then a clean reload
        for (int k = 0; k < 32; k++) ld_bytes[k] = 8'($urandom);
        do_load(0, -1, 10);
        for (int k = 0; k < 32; k++) ld_bytes[k] = 8'($urandom);
        do_load(0, -1, -1);
        for (int i = 0; i < 4; i++) do_read(5'($urandom), d);

        // Randomised loads with stalls and ignored requests
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < 32; k++) ld_bytes[k] = 8'($urandom);
            do_load(1, -1, -1);
            for (int i = 0; i < 4; i++) do_read(5'($urandom), d);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
